sevenseg_ctrl: RTL and testbench
================================

# sevenseg_ctrl

Memory-mapped seven-segment display controller on the RV32 core's data-store bus. It holds one segment register per digit at BASE_ADDR, so existing software that stores raw patterns to 0x400 drives digit 0 unchanged. It time-multiplexes NUM_DIGITS common-anode digits, inserting a ghost-suppression guard interval between digits. It also provides registered read-back, optional hex decoding and per-digit blanking.

## Interface
- BASE_ADDR, 32'h400, word address of digit 0 register
- NUM_DIGITS, 4, number of multiplexed digits, 1..8
- REFRESH_DIV, 50000, drive cycles per digit, >=2
- GUARD_CYCLES, 4, all-anodes-off cycles between digits, >=1
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- wr_en_i  in  1  store strobe, full-word writes only
- wr_addr_i  in  32  store address
- wr_data_i  in  32  store data
- rd_en_i  in  1  load strobe
- rd_addr_i  in  32  load address
- rd_data_o  out  32  load data, registered
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-high
- dp_o  out  1  decimal point, active-high
- an_o  out  NUM_DIGITS  anode enables, active-low

## Operation
- Register map (word offsets from BASE_ADDR):
  - 0x00+4*i DIGITi: [6:0] pattern, [7] dp.
  - 0x40 CTRL: [0] enable, [1] hex_mode.
  - 0x44 BLANK: [NUM_DIGITS-1:0] blank mask.
- Bits outside the defined fields read 0.
- Writes to unmapped addresses, or to DIGITi with i>=NUM_DIGITS, are ignored.
- Reset values: DIGITi=0, CTRL=0x1 (enabled, raw mode), BLANK=0.
- hex_mode=1: DIGITi[3:0] is decoded to segments. Decode table: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, B→7C, C→39, D→5E, E→79, F→71. dp still comes from bit 7.
- FSM states:
  - OFF: entered when enable=0. Prescaler held at 0, index forced to 0.
  - GUARD: runs GUARD_CYCLES cycles with an_o all ones and seg_o=0, dp_o=0. Then goes to DRIVE.
  - DRIVE: runs REFRESH_DIV cycles. an_o=~(1<<index) and seg_o/dp_o are taken from the current digit. At the last cycle, index increments (wrapping NUM_DIGITS-1→0) and the FSM goes to GUARD.
- Reset state is GUARD with index 0.
- Blanked digit: its DRIVE slot is still spent (timing unchanged), but an_o stays all ones and seg_o=0 for that slot.
- enable 1→0 at any state: OFF on the next cycle. enable 0→1: GUARD with index 0.
- Read/write on the same cycle at the same address: rd_data_o returns the pre-write value.
- Read of an unmapped address returns 0.

## Timing
- All outputs are registered.
- Reset values: seg_o=0, dp_o=0, an_o all ones, rd_data_o=0.
- Per-digit period = GUARD_CYCLES+REFRESH_DIV. Full frame = NUM_DIGITS×(GUARD_CYCLES+REFRESH_DIV).
- Write latency: a store accepted at edge N updates the register at N. seg_o/dp_o reflect it at edge N+1 if that digit is in DRIVE and not blanked.
- CTRL or BLANK writes take effect on outputs at edge N+1. The prescaler is not disturbed unless enable changes.
- Read latency: rd_en_i sampled at edge N gives rd_data_o valid after edge N. rd_data_o holds its value when rd_en_i=0.
- rstn low at any cycle returns every register, the FSM, the prescaler and all outputs to reset values at that edge.

## Test plan
- Reset: hold rstn low 5 cycles → seg_o=0, an_o=4'b1111, rd_data_o=0. Then read CTRL → 0x1.
- Legacy store, with REFRESH_DIV=8 and GUARD_CYCLES=2: store 0x3F to 0x400 → 2 cycles of an_o=1111, then 8 cycles of an_o=1110 with seg_o=0x3F. Repeat with 0x06 → seg_o=0x06 one cycle after the store.
- Scan order: DIGIT0..3 = 3F,06,5B,4F → an_o sequence 1110,1101,1011,0111,1110 with matching seg_o. Each digit slot is 10 cycles, frame is 40 cycles, and each guard is 2 cycles of all-off.
- Hex mode: CTRL=0x3, DIGIT1=0x8A → during digit 1, seg_o=0x77 and dp_o=1.
- Blank and disable: BLANK=0x4 → the digit 2 slot shows an_o=1111 for 8 cycles and digit 3 still starts on schedule. Write CTRL=0 mid-DRIVE → an_o=1111 next cycle. Write CTRL=1 → 2-cycle guard, then digit 0.
- Read-back: same-cycle read+write of DIGIT2 (old 0x5B, new 0x7F) → rd_data_o=0x5B. Next read → 0x7F. Read 0x480 → 0. Write 0x480 → no register changes.

Source files
------------

// File: rtl/sevenseg_ctrl_if.sv
// Data-store bus seen by the seven-segment controller: one store port and
// one load port with a registered load-data return.
interface sevenseg_ctrl_if;
  logic        wr_en_i;
  logic [31:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic        rd_en_i;
  logic [31:0] rd_addr_i;
  logic [31:0] rd_data_o;

  // The CPU side issues loads and stores and receives load data
  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
    input  rd_data_o
  );

  // The controller side decodes the accesses and returns load data
  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
    output rd_data_o
  );
endinterface

// File: rtl/sevenseg_ctrl.sv
// Memory-mapped multiplexed seven-segment display controller.
// Holds one segment register per digit plus CTRL and BLANK registers, and scans
// the common-anode digits with an all-off guard interval between digits to
// suppress ghosting.
module sevenseg_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h400,
  parameter int          NUM_DIGITS   = 4,
  parameter int          REFRESH_DIV  = 50000,
  parameter int          GUARD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  sevenseg_ctrl_if.slave        bus,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] an_o
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [31:0] OFF_CTRL  = 32'h40;
  localparam logic [31:0] OFF_BLANK = 32'h44;
  localparam logic [31:0] DIGIT_SPAN = 32'(4 * NUM_DIGITS);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_GUARD,
    ST_DRIVE
  } state_t;

  logic [7:0]            digit_q [NUM_DIGITS];
  logic [1:0]            ctrl_q;
  logic [NUM_DIGITS-1:0] blankMask_q;
  logic [31:0]           rdData_q;

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;

  logic [31:0]           wrOff;
  logic [31:0]           rdOff;
  logic                  wrDigitHit;
  logic                  wrCtrlHit;
  logic                  wrBlankHit;
  logic [IDX_W-1:0]      wrIdx;
  logic [31:0]           rdValue;

  logic [7:0]            curDigit;
  logic                  curBlank;
  logic [NUM_DIGITS-1:0] curOneHot;
  logic [6:0]            driveSeg;
  logic                  driveDp;
  logic [NUM_DIGITS-1:0] driveAn;
  logic                  unusedWrData;

  function automatic logic [6:0] hexDecode(input logic [3:0] value);
    case (value)
      4'h0: hexDecode = 7'h3F;
      4'h1: hexDecode = 7'h06;
      4'h2: hexDecode = 7'h5B;
      4'h3: hexDecode = 7'h4F;
      4'h4: hexDecode = 7'h66;
      4'h5: hexDecode = 7'h6D;
      4'h6: hexDecode = 7'h7D;
      4'h7: hexDecode = 7'h07;
      4'h8: hexDecode = 7'h7F;
      4'h9: hexDecode = 7'h6F;
      4'hA: hexDecode = 7'h77;
      4'hB: hexDecode = 7'h7C;
      4'hC: hexDecode = 7'h39;
      4'hD: hexDecode = 7'h5E;
      4'hE: hexDecode = 7'h79;
      default: hexDecode = 7'h71;
    endcase
  endfunction

  // Only the low data byte and the CTRL/BLANK fields are stored; the rest is dropped
  assign unusedWrData = ^bus.wr_data_i[31:8];

  // Decode store and load addresses relative to the register window
  always_comb begin
    wrOff      = bus.wr_addr_i - BASE_ADDR;
    rdOff      = bus.rd_addr_i - BASE_ADDR;
    wrDigitHit = bus.wr_en_i && (wrOff[1:0] == 2'b00) && (wrOff < DIGIT_SPAN);
    wrCtrlHit  = bus.wr_en_i && (wrOff == OFF_CTRL);
    wrBlankHit = bus.wr_en_i && (wrOff == OFF_BLANK);
    wrIdx      = wrOff[IDX_W+1:2];
    rdValue    = 32'h0;
    if ((rdOff[1:0] == 2'b00) && (rdOff < DIGIT_SPAN)) begin
      rdValue = {24'h0, digit_q[rdOff[IDX_W+1:2]]};
    end else if (rdOff == OFF_CTRL) begin
      rdValue = {30'h0, ctrl_q};
    end else if (rdOff == OFF_BLANK) begin
      rdValue = 32'(blankMask_q);
    end
  end

  // Segment, anode and dp pattern for the digit currently selected by the scan
  always_comb begin
    curDigit          = digit_q[idx_q];
    curBlank          = blankMask_q[idx_q];
    curOneHot         = '0;
    curOneHot[idx_q]  = 1'b1;
    driveSeg          = ctrl_q[1] ? hexDecode(curDigit[3:0]) : curDigit[6:0];
    driveDp           = curDigit[7];
    driveAn           = ~curOneHot;
    if (curBlank) begin
      driveSeg = 7'h0;
      driveDp  = 1'b0;
      driveAn  = '1;
    end
  end

  // Register file updates from full-word stores; unmapped stores fall through
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= 8'h0;
      end
      ctrl_q      <= 2'b01;
      blankMask_q <= '0;
    end else begin
      if (wrDigitHit) begin
        digit_q[wrIdx] <= bus.wr_data_i[7:0];
      end
      if (wrCtrlHit) begin
        ctrl_q <= bus.wr_data_i[1:0];
      end
      if (wrBlankHit) begin
        blankMask_q <= bus.wr_data_i[NUM_DIGITS-1:0];
      end
    end
  end

  // Registered load data; sees the pre-store value when a store hits the same cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdData_q <= 32'h0;
    end else if (bus.rd_en_i) begin
      rdData_q <= rdValue;
    end
  end

  // Scan FSM: guard, drive, next digit; outputs are registered for the state being entered
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_GUARD;
      idx_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= 7'h0;
      dp_q    <= 1'b0;
      an_q    <= '1;
    end else begin
      seg_q <= 7'h0;
      dp_q  <= 1'b0;
      an_q  <= '1;
      if (!ctrl_q[0]) begin
        state_q <= ST_OFF;
        idx_q   <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_OFF: begin
            state_q <= ST_GUARD;
            idx_q   <= '0;
            cnt_q   <= '0;
          end
          ST_GUARD: begin
            if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
              state_q <= ST_DRIVE;
              cnt_q   <= '0;
              seg_q   <= driveSeg;
              dp_q    <= driveDp;
              an_q    <= driveAn;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_DRIVE: begin
            if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
              state_q <= ST_GUARD;
              cnt_q   <= '0;
              idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              seg_q <= driveSeg;
              dp_q  <= driveDp;
              an_q  <= driveAn;
            end
          end
          default: begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign seg_o         = seg_q;
  assign dp_o          = dp_q;
  assign an_o          = an_q;
  assign bus.rd_data_o = rdData_q;

endmodule

// File: tb/tb_sevenseg_ctrl.sv
// Bench for the seven-segment controller: a directed walk through the main
// behaviours followed by randomized bus traffic, all compared every cycle
// against a frame-position model of the display and a simple register map.
module tb_sevenseg_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int GC    = 2;
  localparam int SLOT  = RD + GC;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rstn;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;

  sevenseg_ctrl_if bus();

  sevenseg_ctrl #(
    .BASE_ADDR    (32'h400),
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus   (bus),
    .seg_o (seg),
    .dp_o  (dp),
    .an_o  (an)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  logic [6:0]    hexTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [31:0]   addrList [12] = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410, 32'h41C,
                                   32'h440, 32'h444, 32'h448, 32'h480, 32'h000, 32'h800};

  logic [7:0]    mDigit [ND];
  logic [1:0]    mCtrl;
  logic [ND-1:0] mBlank;
  int            mT;
  bit            mOff;
  logic [31:0]   mRd;
  logic [6:0]    eSeg;
  logic          eDp;
  logic [ND-1:0] eAn;

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'h400;
    if (off < 32'(4 * ND) && off % 4 == 0) return {24'h0, mDigit[int'(off >> 2)]};
    if (off == 32'h40) return {30'h0, mCtrl};
    if (off == 32'h44) return {28'h0, mBlank};
    return 32'h0;
  endfunction

  // Advance the model by one clock edge using the inputs the DUT just sampled
  task automatic modelEdge();
    int pos, slot, ph;
    logic [31:0] off;
    if (!rstn) begin
      for (int i = 0; i < ND; i++) mDigit[i] = 8'h0;
      mCtrl  = 2'b01;
      mBlank = '0;
      mT     = 0;
      mOff   = 0;
      mRd    = 32'h0;
      eSeg   = 7'h0;
      eDp    = 1'b0;
      eAn    = '1;
    end else begin
      eSeg = 7'h0;
      eDp  = 1'b0;
      eAn  = '1;
      if (!mCtrl[0]) begin
        mOff = 1;
      end else begin
        if (mOff) mT = 0;
        else mT++;
        mOff = 0;
        pos  = mT % FRAME;
        slot = pos / SLOT;
        ph   = pos % SLOT;
        if (ph >= GC && !mBlank[slot]) begin
          eSeg       = mCtrl[1] ? hexTable[mDigit[slot][3:0]] : mDigit[slot][6:0];
          eDp        = mDigit[slot][7];
          eAn        = '1;
          eAn[slot]  = 1'b0;
        end
      end
      if (bus.rd_en_i) mRd = modelRead(bus.rd_addr_i);
      if (bus.wr_en_i) begin
        off = bus.wr_addr_i - 32'h400;
        if (off < 32'(4 * ND) && off % 4 == 0) mDigit[int'(off >> 2)] = bus.wr_data_i[7:0];
        else if (off == 32'h40) mCtrl = bus.wr_data_i[1:0];
        else if (off == 32'h44) mBlank = bus.wr_data_i[ND-1:0];
      end
    end
  endtask

  // Drive one cycle of inputs, step the model at the edge, check on the falling edge
  task automatic applyStimulus(input bit r, input bit we, input logic [31:0] wa,
                               input logic [31:0] wd, input bit re, input logic [31:0] ra);
    rstn          = r;
    bus.wr_en_i   = we;
    bus.wr_addr_i = wa;
    bus.wr_data_i = wd;
    bus.rd_en_i   = re;
    bus.rd_addr_i = ra;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput("seg_o", 32'(seg), 32'(eSeg));
    checkOutput("dp_o", 32'(dp), 32'(eDp));
    checkOutput("an_o", 32'(an), 32'(eAn));
    checkOutput("rd_data_o", bus.rd_data_o, mRd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1, 1, a, d, 0, 32'h0);
  endtask

  task automatic load(input logic [31:0] a);
    applyStimulus(1, 0, 32'h0, 32'h0, 1, a);
  endtask

  initial begin
    logic [31:0] wa, wd, ra;
    bit r, we, re;
    rstn = 0;
    bus.wr_en_i = 0; bus.wr_addr_i = 0; bus.wr_data_i = 0;
    bus.rd_en_i = 0; bus.rd_addr_i = 0;

    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 32'h0, 32'h0, 0, 32'h0);
    load(32'h440);
    store(32'h400, 32'h3F);
    idle(12);
    store(32'h400, 32'h06);
    idle(10);

    store(32'h400, 32'h3F); store(32'h404, 32'h06);
    store(32'h408, 32'h5B); store(32'h40C, 32'h4F);
    idle(45);

    store(32'h440, 32'h3); store(32'h404, 32'h8A);
    idle(40);
    store(32'h440, 32'h1); store(32'h444, 32'h4);
    idle(40);
    store(32'h444, 32'h0);
    idle(5);
    store(32'h440, 32'h0);
    idle(3);
    store(32'h440, 32'h1);
    idle(15);

    applyStimulus(1, 1, 32'h408, 32'h7F, 1, 32'h408);
    load(32'h408);
    load(32'h480);
    store(32'h480, 32'hFFFF_FFFF);
    load(32'h400); load(32'h404); load(32'h408); load(32'h40C);
    load(32'h440); load(32'h444);
    idle(20);

    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 999) != 0);
      we = ($urandom_range(0, 7) == 0);
      wa = addrList[$urandom_range(0, 11)];
      wd = $urandom;
      if (wa == 32'h440 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      re = $urandom_range(0, 1) == 1;
      ra = addrList[$urandom_range(0, 11)];
      applyStimulus(r, we, wa, wd, re, ra);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
